vga_event_queue: RTL and testbench
==================================

VGA_EVENT_QUEUE -- requirements
Module: vga_event_queue

Interface
REQ-001 Parameter DRAW_GAP, default 18: total cycles one event is presented to the display stage (issue + hold); legal range 2..63.
REQ-002 Parameter DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-003 iClock  input  1  single clock; all state updates on its rising edge.
REQ-004 iResetn  input  1  reset, synchronous, active-low.
REQ-005 iNoteValid  input  1  level from key decoder; high while a note key is held.
REQ-006 iNote  input  4  note code 0..11, sampled with iNoteValid.
REQ-007 iOctUp, iOctDn, iAdsrUp, iAdsrDn  input  1 each  level button requests.
REQ-008 oNote  output  4  note code presented to the display stage.
REQ-009 oNoteIn  output  1  one-cycle draw-start strobe.
REQ-010 oOctavePlusPlus, oOctaveMinusMinus, oAdsrPlusPlus, oAdsrMinusMinus  output  1 each  position-override flags for the display stage.
REQ-011 oOverflow  output  1  sticky event-dropped flag (present only with the Configuration macro).
REQ-012 oLevel  output  5  current FIFO occupancy (present only with the Configuration macro).

Function
REQ-013 All seven inputs SHALL be registered twice; a rising edge SHALL be detected as first-stage high and second-stage low.
REQ-014 A note rising edge SHALL capture iNote from the first register stage; codes 12..15 SHALL be discarded silently.
REQ-015 Each of the five sources SHALL have one pending bit, set on its rising edge and cleared when its event is enqueued.
REQ-016 At most one event per cycle SHALL be enqueued, fixed priority: note > OctUp > OctDn > AdsrUp > AdsrDn.
REQ-017 An edge arriving while its source pending bit is already set SHALL be dropped and SHALL set overflow.
REQ-018 A pending event SHALL be dropped and SHALL set overflow if the FIFO is full when it wins arbitration.
REQ-019 FIFO entry: 3-bit type (note, octup, octdn, adsrup, adsrdn) plus 4-bit note; pointers SHALL wrap modulo DEPTH.
REQ-020 FSM states: IDLE, ISSUE, HOLD; reset state IDLE.
REQ-021 IDLE: when the FIFO is non-empty, pop the head, load the output registers, go to ISSUE; otherwise stay.
REQ-022 ISSUE lasts exactly one cycle with oNoteIn=1, then goes to HOLD.
REQ-023 HOLD SHALL last DRAW_GAP-1 cycles, counted by a 6-bit counter, then return to IDLE with all outputs cleared to 0.
REQ-024 During ISSUE and HOLD, oNote and the one flag matching the event type SHALL stay constant; all other flags SHALL be 0.
REQ-025 Note events SHALL present the queued code; non-note events SHALL present oNote=4'hF.
REQ-026 In IDLE, oNoteIn, oNote and all flags SHALL be 0.
REQ-027 Latency: with the FIFO empty and the FSM in IDLE, oNoteIn SHALL be high in the 4th cycle after the clock edge that first samples the input high.
REQ-028 Back-to-back events SHALL produce oNoteIn strobes exactly DRAW_GAP+1 cycles apart (one IDLE cycle between them).
REQ-029 An enqueue and a pop in the same cycle on a full FIFO SHALL both proceed, with no drop.

Reset
REQ-030 iResetn low at a rising edge SHALL clear all outputs, pending bits, edge registers, counter and pointers, empty the FIFO, clear oOverflow, and force IDLE.
REQ-031 Reset during ISSUE or HOLD SHALL abort the event; it is not replayed.
REQ-032 Inputs held high through reset release SHALL NOT generate an event.

Configuration
REQ-033 Macro VGA_EVQ_STATUS_EN defined: oOverflow and oLevel exist; oOverflow is set by REQ-017/018 and cleared only by reset; oLevel = occupancy 0..DEPTH.
REQ-034 VGA_EVQ_STATUS_EN undefined: both ports and the overflow register are absent; drops are silent; all other behaviour is identical.

Verification
REQ-035 Reset, then iNoteValid rises with iNote=4 -> oNoteIn strobe at cycle +4, oNote=4 held for 18 cycles, then oNote=0.
REQ-036 iOctUp and iAdsrDn rise in the same cycle -> two events in order OctUp then AdsrDn; strobes 19 cycles apart; oNote=F for both.
REQ-037 Six distinct edges in quick succession, DEPTH=4 -> exactly five strobes (one in flight plus four queued); oOverflow=1; oLevel peaks at 4.
REQ-038 iNoteValid rises with iNote=13 -> no strobe, oOverflow stays 0.
REQ-039 Reset asserted in the 5th HOLD cycle with 2 events queued -> next cycle all outputs 0, oLevel=0, no further strobes.
REQ-040 iNoteValid held high across reset release -> no event; the next 0->1 transition produces one strobe.

Source files
------------

// File: rtl/vga_event_queue.sv
// Edge-detects note and button requests, queues them in a DEPTH-entry FIFO and presents each
// to the display stage for DRAW_GAP cycles. Defining VGA_EVQ_STATUS_EN adds oOverflow and oLevel.
module vga_event_queue #(
    parameter int DRAW_GAP = 18,
    parameter int DEPTH    = 4
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iNoteValid,
    input  logic [3:0] iNote,
    input  logic       iOctUp,
    input  logic       iOctDn,
    input  logic       iAdsrUp,
    input  logic       iAdsrDn,
    output logic [3:0] oNote,
    output logic       oNoteIn,
    output logic       oOctavePlusPlus,
    output logic       oOctaveMinusMinus,
    output logic       oAdsrPlusPlus,
    output logic       oAdsrMinusMinus
`ifdef VGA_EVQ_STATUS_EN
    ,
    output logic       oOverflow,
    output logic [4:0] oLevel
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;
    typedef enum logic [2:0] {EV_NOTE, EV_OCTUP, EV_OCTDN, EV_ADSRUP, EV_ADSRDN} ev_e;
    typedef struct packed {
        ev_e        kind;
        logic [3:0] note;
    } entry_t;

    logic [8:0]    raw, s1_q, s2_q;
    logic [4:0]    rise, edge_v, pend_q, pend_d, win_oh;
    logic [2:0]    win_idx;
    logic [3:0]    note_code_q, note_code_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          enq_valid, full, empty, push, pop;
    entry_t        mem [DEPTH];
    entry_t        head, wr_entry;
    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [3:0]    note_q, note_d, flags_q, flags_d;
    logic          strobe_q, strobe_d;

    // Bit order: {note[3:0], adsr_dn, adsr_up, oct_dn, oct_up, note_valid}.
    assign raw    = {iNote, iAdsrDn, iAdsrUp, iOctDn, iOctUp, iNoteValid};
    assign rise   = s1_q[4:0] & ~s2_q[4:0];
    assign edge_v = {rise[4:1], rise[0] & (s1_q[8:5] < 4'd12)};

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int i = 4; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_idx    = 3'(i);
            end
        end
    end

    assign enq_valid     = |pend_q;
    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign push          = enq_valid && (!full || pop);
    assign pend_d        = (pend_q & ~win_oh) | (edge_v & ~pend_q);
    assign note_code_d   = (edge_v[0] && !pend_q[0]) ? s1_q[8:5] : note_code_q;
    assign wr_entry.kind = ev_e'(win_idx);
    assign wr_entry.note = note_code_q;
    assign head          = mem[rd_ptr_q];

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        note_d   = note_q;
        flags_d  = flags_q;
        strobe_d = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                note_d  = '0;
                flags_d = '0;
                if (!empty) begin
                    pop      = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = ISSUE;
                    note_d   = (head.kind == EV_NOTE) ? head.note : 4'hF;
                    case (head.kind)
                        EV_OCTUP:  flags_d = 4'b1000;
                        EV_OCTDN:  flags_d = 4'b0100;
                        EV_ADSRUP: flags_d = 4'b0010;
                        EV_ADSRDN: flags_d = 4'b0001;
                        default:   flags_d = 4'b0000;
                    endcase
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == 6'(DRAW_GAP - 2)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    note_d  = '0;
                    flags_d = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            // NOTE: both stages track the live inputs during reset, so a level already high at
            // release looks old and produces no edge.
            s1_q        <= raw;
            s2_q        <= raw;
            pend_q      <= '0;
            note_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            note_q      <= '0;
            flags_q     <= '0;
            strobe_q    <= 1'b0;
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            pend_q      <= pend_d;
            note_code_q <= note_code_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            note_q      <= note_d;
            flags_q     <= flags_d;
            strobe_q    <= strobe_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers and occupancy define which entries are valid.
    always_ff @(posedge iClock) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

`ifdef VGA_EVQ_STATUS_EN
    logic overflow_q, drop;
    assign drop = (enq_valid && !push) || (|(edge_v & pend_q));

    always_ff @(posedge iClock) begin
        if (!iResetn) overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

    assign oOverflow = overflow_q;
    assign oLevel    = 5'(count_q);
`endif

    assign oNote             = note_q;
    assign oNoteIn           = strobe_q;
    assign oOctavePlusPlus   = flags_q[3];
    assign oOctaveMinusMinus = flags_q[2];
    assign oAdsrPlusPlus     = flags_q[1];
    assign oAdsrMinusMinus   = flags_q[0];
endmodule

// File: tb/tb_vga_event_queue.sv
// Directed bench for vga_event_queue with default parameters (DRAW_GAP=18, DEPTH=4).
module tb_vga_event_queue;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       note_valid = 1'b0, oct_up = 1'b0, oct_dn = 1'b0, adsr_up = 1'b0, adsr_dn = 1'b0;
    logic [3:0] note = 4'd0;
    logic [3:0] o_note;
    logic       o_note_in, o_opp, o_omm, o_app, o_amm;
`ifdef VGA_EVQ_STATUS_EN
    logic       o_overflow;
    logic [4:0] o_level;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int peak = 0;
    int s_cyc[$];
    logic [3:0] s_note[$];
    logic [3:0] s_flags[$];

    vga_event_queue dut (
        .iClock(clk), .iResetn(rstn), .iNoteValid(note_valid), .iNote(note),
        .iOctUp(oct_up), .iOctDn(oct_dn), .iAdsrUp(adsr_up), .iAdsrDn(adsr_dn),
        .oNote(o_note), .oNoteIn(o_note_in), .oOctavePlusPlus(o_opp),
        .oOctaveMinusMinus(o_omm), .oAdsrPlusPlus(o_app), .oAdsrMinusMinus(o_amm)
`ifdef VGA_EVQ_STATUS_EN
        , .oOverflow(o_overflow), .oLevel(o_level)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: cycle index, presented note and {oct++, oct--, adsr++, adsr--} at each strobe.
    always @(negedge clk) begin
        if (o_note_in === 1'b1) begin
            s_cyc.push_back(cyc);
            s_note.push_back(o_note);
            s_flags.push_back({o_opp, o_omm, o_app, o_amm});
        end
`ifdef VGA_EVQ_STATUS_EN
        if (int'(o_level) > peak) peak = int'(o_level);
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_note.delete();
        s_flags.delete();
        peak = 0;
    endtask

    task automatic clear_inputs();
        note_valid = 1'b0; oct_up = 1'b0; oct_dn = 1'b0; adsr_up = 1'b0; adsr_dn = 1'b0;
        note = 4'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        clear_inputs();
        @(posedge clk); #1;
        rstn = 1'b0;
        tick(2);
        @(negedge clk);
        vectors++;
        if ({o_note_in, o_note, o_opp, o_omm, o_app, o_amm} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {o_note_in, o_note, o_opp, o_omm, o_app, o_amm});
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if ({o_overflow, o_level} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_status: got %b expected 000000", {o_overflow, o_level});
        end
`endif
        rstn = 1'b1;
        clear_log();
    endtask

    task automatic test_note_latency();
        int c0;
        clear_inputs();
        do_reset();
        tick(2);
        c0 = cyc;
        note_valid = 1'b1;
        note = 4'd4;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            vectors++;
            if (o_note_in !== (k == 4)) begin
                miscompares++;
                $display("FAIL latency_strobe k=%0d: got %b expected %b", k, o_note_in, k == 4);
            end
            vectors++;
            if (o_note !== ((k >= 4 && k <= 21) ? 4'd4 : 4'd0)) begin
                miscompares++;
                $display("FAIL latency_note k=%0d: got %0h expected %0h", k, o_note,
                         (k >= 4 && k <= 21) ? 4'd4 : 4'd0);
            end
            if (k == 10) begin
                vectors++;
                if ({o_opp, o_omm, o_app, o_amm} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL latency_flags: got %b expected 0000", {o_opp, o_omm, o_app, o_amm});
                end
            end
        end
        note_valid = 1'b0;
        tick(5);
        vectors++;
        if (s_cyc.size() !== 1) begin
            miscompares++;
            $display("FAIL latency_count: got %0d expected 1", s_cyc.size());
        end
    endtask

    task automatic test_two_buttons();
        int c0;
        clear_inputs();
        do_reset();
        tick(2);
        c0 = cyc;
        oct_up = 1'b1;
        adsr_dn = 1'b1;
        tick(3);
        clear_inputs();
        tick(50);
        vectors++;
        if (s_cyc.size() !== 2) begin
            miscompares++;
            $display("FAIL pair_count: got %0d expected 2", s_cyc.size());
        end else begin
            vectors++;
            if (s_cyc[0] !== c0 + 4) begin
                miscompares++;
                $display("FAIL pair_first_cycle: got %0d expected %0d", s_cyc[0], c0 + 4);
            end
            vectors++;
            if (s_cyc[1] - s_cyc[0] !== 19) begin
                miscompares++;
                $display("FAIL pair_gap: got %0d expected 19", s_cyc[1] - s_cyc[0]);
            end
            vectors++;
            if ({s_flags[0], s_flags[1]} !== 8'b1000_0001) begin
                miscompares++;
                $display("FAIL pair_order: got %b expected 10000001", {s_flags[0], s_flags[1]});
            end
            vectors++;
            if ({s_note[0], s_note[1]} !== 8'hFF) begin
                miscompares++;
                $display("FAIL pair_note: got %0h expected ff", {s_note[0], s_note[1]});
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_flags [5];
        exp_flags = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        clear_inputs();
        do_reset();
        tick(2);
        note_valid = 1'b1; note = 4'd7;
        oct_up = 1'b1; oct_dn = 1'b1; adsr_up = 1'b1; adsr_dn = 1'b1;
        tick(3);
        clear_inputs();
        tick(5);
        note_valid = 1'b1;
        note = 4'd2;
        tick(4);
        note_valid = 1'b0;
        tick(100);
        vectors++;
        if (s_cyc.size() !== 5) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d expected 5", s_cyc.size());
        end else begin
            vectors++;
            if (s_note[0] !== 4'd7) begin
                miscompares++;
                $display("FAIL ovf_note: got %0h expected 7", s_note[0]);
            end
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (s_flags[i] !== exp_flags[i]) begin
                    miscompares++;
                    $display("FAIL ovf_order[%0d]: got %b expected %b", i, s_flags[i], exp_flags[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                vectors++;
                if (s_cyc[i] - s_cyc[i-1] !== 19) begin
                    miscompares++;
                    $display("FAIL ovf_gap[%0d]: got %0d expected 19", i, s_cyc[i] - s_cyc[i-1]);
                end
            end
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if (o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b expected 1", o_overflow);
        end
        vectors++;
        if (peak !== 4) begin
            miscompares++;
            $display("FAIL ovf_peak: got %0d expected 4", peak);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        int c0;
        clear_inputs();
        do_reset();
        tick(2);
        c0 = cyc;
        note_valid = 1'b1; note = 4'd3;
        oct_up = 1'b1; oct_dn = 1'b1; adsr_up = 1'b1; adsr_dn = 1'b1;
        tick(2);
        clear_inputs();
        tick(18);
        oct_up = 1'b1;
        tick(2);
        oct_up = 1'b0;
        tick(100);
        vectors++;
        if (s_cyc.size() !== 6) begin
            miscompares++;
            $display("FAIL fullpp_count: got %0d expected 6", s_cyc.size());
        end else begin
            vectors++;
            if (s_cyc[5] !== c0 + 99) begin
                miscompares++;
                $display("FAIL fullpp_cycle: got %0d expected %0d", s_cyc[5], c0 + 99);
            end
            vectors++;
            if (s_flags[5] !== 4'b1000) begin
                miscompares++;
                $display("FAIL fullpp_kind: got %b expected 1000", s_flags[5]);
            end
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if (o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpp_overflow: got %b expected 0", o_overflow);
        end
`endif
    endtask

    task automatic test_bad_code();
        clear_inputs();
        do_reset();
        tick(2);
        note = 4'd13;
        note_valid = 1'b1;
        tick(30);
        note_valid = 1'b0;
        tick(2);
        vectors++;
        if (s_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL badcode_count: got %0d expected 0", s_cyc.size());
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if ({o_overflow, o_level} !== 6'd0) begin
            miscompares++;
            $display("FAIL badcode_status: got %b expected 000000", {o_overflow, o_level});
        end
`endif
    endtask

    task automatic test_reset_abort();
        clear_inputs();
        do_reset();
        tick(2);
        oct_up = 1'b1; oct_dn = 1'b1; adsr_up = 1'b1;
        tick(2);
        clear_inputs();
        tick(7);
        vectors++;
        if ({o_opp, o_note} !== 5'b1_1111) begin
            miscompares++;
            $display("FAIL abort_hold: got %b expected 11111", {o_opp, o_note});
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if (o_level !== 5'd2) begin
            miscompares++;
            $display("FAIL abort_level_pre: got %0d expected 2", o_level);
        end
`endif
        rstn = 1'b0;
        tick(1);
        vectors++;
        if ({o_note_in, o_note, o_opp, o_omm, o_app, o_amm} !== 9'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %b expected 000000000",
                     {o_note_in, o_note, o_opp, o_omm, o_app, o_amm});
        end
`ifdef VGA_EVQ_STATUS_EN
        vectors++;
        if (o_level !== 5'd0) begin
            miscompares++;
            $display("FAIL abort_level: got %0d expected 0", o_level);
        end
`endif
        rstn = 1'b1;
        tick(60);
        vectors++;
        if (s_cyc.size() !== 1) begin
            miscompares++;
            $display("FAIL abort_count: got %0d expected 1", s_cyc.size());
        end
    endtask

    task automatic test_reset_held();
        clear_inputs();
        @(posedge clk); #1;
        rstn = 1'b0;
        note_valid = 1'b1;
        note = 4'd5;
        tick(3);
        rstn = 1'b1;
        clear_log();
        tick(30);
        vectors++;
        if (s_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL held_count: got %0d expected 0", s_cyc.size());
        end
        note_valid = 1'b0;
        tick(3);
        note_valid = 1'b1;
        tick(30);
        note_valid = 1'b0;
        tick(2);
        vectors++;
        if (s_cyc.size() !== 1) begin
            miscompares++;
            $display("FAIL held_rearm_count: got %0d expected 1", s_cyc.size());
        end else begin
            vectors++;
            if (s_note[0] !== 4'd5) begin
                miscompares++;
                $display("FAIL held_rearm_note: got %0h expected 5", s_note[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_latency();
        test_two_buttons();
        test_overflow();
        test_full_push_pop();
        test_bad_code();
        test_reset_abort();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
